// File: rtl/dm_sba_to_axi_lite_pkg.sv
// rtl/dm_sba_to_axi_lite_pkg.sv - shared AXI-Lite bridge state encodings and response codes
package dm_sba_to_axi_lite_pkg;

    typedef enum logic [2:0] {
        SL_IDLE   = 3'd0,
        SL_WRITE  = 3'd1,
        SL_WRESP  = 3'd2,
        SL_READ   = 3'd3,
        SL_RRESP  = 3'd4
    } axi_state_slave_t;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESPOND      = 3'd5,
        DRAIN        = 3'd6
    } axi_state_master_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/dm_sba_to_axi_lite_if.sv
// rtl/dm_sba_to_axi_lite_if.sv - AXI-Lite bus interface with master/slave modports
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/dm_sba_to_axi_lite.sv
// rtl/dm_sba_to_axi_lite.sv - debug SBA request port to AXI-Lite master bridge; optional DM_SBA_TIMEOUT_EN
module dm_sba_to_axi_lite
    import dm_sba_to_axi_lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        host_req_i,
    output logic                        host_gnt_o,
    input  logic                        host_we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   host_addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] host_be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   host_wdata_i,
    output logic                        host_r_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]   host_r_rdata_o,
    output logic                        host_r_err_o,
    axi_lite_if.master                  m_axi_lite
);

    axi_state_master_t           state;
    logic                        we_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH/8-1:0] be_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic                        awvalid_q, wvalid_q, aw_done, w_done;
    logic                        bready_q, arvalid_q, rready_q;
    logic                        r_valid_q, err_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;

    logic hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_fin, w_fin;

    assign hs_aw  = awvalid_q && m_axi_lite.awready;
    assign hs_w   = wvalid_q  && m_axi_lite.wready;
    assign hs_b   = bready_q  && m_axi_lite.bvalid;
    assign hs_ar  = arvalid_q && m_axi_lite.arready;
    assign hs_r   = rready_q  && m_axi_lite.rvalid;
    assign aw_fin = aw_done || hs_aw;
    assign w_fin  = w_done  || hs_w;

    assign host_gnt_o     = host_req_i && (state == IDLE);
    assign host_r_valid_o = r_valid_q;
    assign host_r_rdata_o = rdata_q;
    assign host_r_err_o   = err_q;

    assign m_axi_lite.awaddr  = addr_q;
    assign m_axi_lite.awprot  = 3'b000;
    assign m_axi_lite.awvalid = awvalid_q;
    assign m_axi_lite.wdata   = wdata_q;
    assign m_axi_lite.wstrb   = be_q;
    assign m_axi_lite.wvalid  = wvalid_q;
    assign m_axi_lite.bready  = bready_q;
    assign m_axi_lite.araddr  = addr_q;
    assign m_axi_lite.arprot  = 3'b000;
    assign m_axi_lite.arvalid = arvalid_q;
    assign m_axi_lite.rready  = rready_q;

`ifdef DM_SBA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    axi_state_master_t prev_state;
    logic [CNT_W-1:0]  tmo_cnt, cnt_cur;
    logic              timed_out, in_wait, progress, tmo_fire, draining;

    // The count reads as zero in the first cycle of any state, so each phase gets its own budget.
    assign cnt_cur  = (state != prev_state) ? '0 : tmo_cnt;
    assign in_wait  = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                      (state == RD_ADDR) || (state == RD_DATA);
    assign progress = ((state == WR_ADDR_DATA) && aw_fin && w_fin) ||
                      ((state == WR_RESP) && hs_b) ||
                      ((state == RD_ADDR) && hs_ar) ||
                      ((state == RD_DATA) && hs_r);
    assign tmo_fire = in_wait && !progress && (cnt_cur == CNT_W'(TIMEOUT_CYCLES - 1));
    assign draining = (state == DRAIN) || ((state == RESPOND) && timed_out);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_state <= IDLE;
            tmo_cnt    <= '0;
        end else begin
            prev_state <= state;
            tmo_cnt    <= in_wait ? cnt_cur + CNT_W'(1) : '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            r_valid_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef DM_SBA_TIMEOUT_EN
            timed_out <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (host_req_i) begin
                        we_q    <= host_we_i;
                        addr_q  <= host_addr_i;
                        be_q    <= host_be_i;
                        wdata_q <= host_wdata_i;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (host_we_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (hs_aw) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (hs_w) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (hs_b) begin
                        bready_q  <= 1'b0;
                        err_q     <= (m_axi_lite.bresp != AXI_RESP_OKAY);
                        rdata_q   <= '0;
                        r_valid_q <= 1'b1;
                        state     <= RESPOND;
                    end
                end
                RD_ADDR: begin
                    if (hs_ar) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (hs_r) begin
                        rready_q  <= 1'b0;
                        rdata_q   <= m_axi_lite.rdata;
                        err_q     <= (m_axi_lite.rresp != AXI_RESP_OKAY);
                        r_valid_q <= 1'b1;
                        state     <= RESPOND;
                    end
                end
                RESPOND: begin
                    r_valid_q <= 1'b0;
`ifdef DM_SBA_TIMEOUT_EN
                    timed_out <= 1'b0;
                    state     <= (timed_out && !(hs_b || hs_r)) ? DRAIN : IDLE;
`else
                    state     <= IDLE;
`endif
                end
`ifdef DM_SBA_TIMEOUT_EN
                DRAIN: begin
                    if (hs_b || hs_r) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
`ifdef DM_SBA_TIMEOUT_EN
            // After a timeout the AXI side still owes a completion; keep the channels
            // legal until it arrives and throw the result away.
            if (draining) begin
                if (hs_aw) begin
                    awvalid_q <= 1'b0;
                    aw_done   <= 1'b1;
                end
                if (hs_w) begin
                    wvalid_q <= 1'b0;
                    w_done   <= 1'b1;
                end
                if (hs_ar) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                end
                if (we_q && aw_fin && w_fin) bready_q <= 1'b1;
                if (hs_b || hs_r) begin
                    bready_q <= 1'b0;
                    rready_q <= 1'b0;
                end
            end
            if (tmo_fire) begin
                r_valid_q <= 1'b1;
                err_q     <= 1'b1;
                rdata_q   <= '0;
                timed_out <= 1'b1;
                state     <= RESPOND;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dm_sba_to_axi_lite.sv
// tb/tb_dm_sba_to_axi_lite.sv - self-checking bench for the SBA to AXI-Lite bridge
module tb_dm_sba_to_axi_lite;
    import dm_sba_to_axi_lite_pkg::*;

`ifdef DM_SBA_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_req_i = 1'b0;
    logic        host_gnt_o;
    logic        host_we_i = 1'b0;
    logic [31:0] host_addr_i = '0;
    logic [3:0]  host_be_i = '0;
    logic [31:0] host_wdata_i = '0;
    logic        host_r_valid_o;
    logic [31:0] host_r_rdata_o;
    logic        host_r_err_o;

    always #5 clk = ~clk;

    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    dm_sba_to_axi_lite #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_we_i(host_we_i),
        .host_addr_i(host_addr_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_r_valid_o(host_r_valid_o), .host_r_rdata_o(host_r_rdata_o),
        .host_r_err_o(host_r_err_o), .m_axi_lite(axi)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  resp;
        logic [31:0] rd;
        bit          keep;
        int          exp_lat;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] last_rdata = '0;
    vec_t        vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Phase lengths: address phase lasts until the slower of AW/W is accepted,
    // then the response phase, then one RESPOND cycle.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.we) r.exp_lat = ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + 1 + v.b_d + 1 + 1;
        else      r.exp_lat = v.ar_d + 1 + v.r_d + 1 + 1;
        r.exp_err   = (v.resp != 2'b00);
        r.exp_rdata = v.we ? 32'h0 : v.rd;
        return r;
    endfunction

    task automatic axi_idle();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0;  axi.bresp = 2'b00;
        axi.rvalid = 1'b0;  axi.rresp = 2'b00; axi.rdata = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctrl"}, {24'h0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
                             axi.rready, host_gnt_o, host_r_valid_o, host_r_err_o}, 32'h0);
        chk({tag, "_addr"}, axi.awaddr | axi.araddr, 32'h0);
        chk({tag, "_wdata"}, axi.wdata | {28'h0, axi.wstrb}, 32'h0);
        chk({tag, "_rdata"}, host_r_rdata_o, 32'h0);
    endtask

    task automatic do_txn(input vec_t v);
        int c = 0, lat = -1, rv_cnt = 0, viol = 0, fbad = 0, gbad = 0;
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        bit aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0;
        bit awv_p = 0, wv_p = 0, arv_p = 0, bry_p = 0, rry_p = 0;
        logic [31:0] got_rdata = 'x;
        logic        got_err = 1'bx;
        @(negedge clk);
        chk("idle_rvalid", host_r_valid_o, 0);
        chk("idle_rdata_hold", host_r_rdata_o, last_rdata);
        axi_idle();
        host_req_i = 1'b1; host_we_i = v.we; host_addr_i = v.addr;
        host_be_i = v.be; host_wdata_i = v.wdata;
        #1 chk("gnt", host_gnt_o, 1);
        while (rv_cnt == 0 && c < 200) begin
            @(negedge clk);
            c++;
            if (host_req_i && host_gnt_o) gbad++;
            host_req_i = 1'($urandom_range(0, 1)); host_we_i = 1'($urandom_range(0, 1));
            host_addr_i = $urandom; host_be_i = 4'($urandom); host_wdata_i = $urandom;
            if (awv_p && axi.awready) aw_done = 1;
            if (wv_p && axi.wready) w_done = 1;
            if (arv_p && axi.arready) ar_done = 1;
            if (bry_p && axi.bvalid) b_done = 1;
            if (rry_p && axi.rvalid) r_done = 1;
            if (axi.awvalid && (aw_done || !v.we)) viol++;
            if (axi.wvalid && (w_done || !v.we)) viol++;
            if (axi.arvalid && (ar_done || v.we)) viol++;
            if (awv_p && !aw_done && !axi.awvalid) viol++;
            if (wv_p && !w_done && !axi.wvalid) viol++;
            if (arv_p && !ar_done && !axi.arvalid) viol++;
            if ((axi.bready && !v.we) || (axi.rready && v.we)) viol++;
            if (axi.awvalid && (axi.awaddr !== v.addr || axi.awprot !== 3'b000)) fbad++;
            if (axi.wvalid && (axi.wdata !== v.wdata || axi.wstrb !== v.be)) fbad++;
            if (axi.arvalid && (axi.araddr !== v.addr || axi.arprot !== 3'b000)) fbad++;
            if (host_r_valid_o) begin
                rv_cnt++; lat = c; got_rdata = host_r_rdata_o; got_err = host_r_err_o;
                host_req_i = v.keep;
            end
            if (axi.awvalid && !aw_done) aw_cnt++;
            if (axi.wvalid && !w_done) w_cnt++;
            if (axi.arvalid && !ar_done) ar_cnt++;
            if (aw_done && w_done && !b_done) b_cnt++;
            if (ar_done && !r_done) r_cnt++;
            axi.awready = axi.awvalid && !aw_done && (aw_cnt > v.aw_d);
            axi.wready  = axi.wvalid && !w_done && (w_cnt > v.w_d);
            axi.arready = axi.arvalid && !ar_done && (ar_cnt > v.ar_d);
            axi.bvalid  = aw_done && w_done && !b_done && (b_cnt > v.b_d);
            axi.bresp   = v.resp;
            axi.rvalid  = ar_done && !r_done && (r_cnt > v.r_d);
            axi.rresp   = v.resp;
            axi.rdata   = v.rd;
            awv_p = axi.awvalid; wv_p = axi.wvalid; arv_p = axi.arvalid;
            bry_p = axi.bready;  rry_p = axi.rready;
        end
        axi_idle();
        chk("rvalid_seen", rv_cnt, 1);
        chk("latency", lat, v.exp_lat);
        chk("rdata", got_rdata, v.exp_rdata);
        chk("err", got_err, v.exp_err);
        chk("axi_fields_bad", fbad, 0);
        chk("protocol_viol", viol, 0);
        chk("gnt_while_busy", gbad, 0);
        last_rdata = got_rdata;
    endtask

    initial begin
        vec_t v;
        int   rv_bad;
        vecs[0] = '{1'b1, 32'h8000_0010, 4'hF, 32'hCAFE_F00D, 0, 0, 0, 0, 0, AXI_RESP_OKAY,
                    32'h0, 1'b0, 3, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h4000_0004, 4'hF, 32'h0, 0, 0, 0, 4, 2, AXI_RESP_OKAY,
                    32'h1234_5678, 1'b0, 9, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'h8000_0020, 4'h3, 32'h0000_BEEF, 3, 0, 0, 0, 0, AXI_RESP_OKAY,
                    32'h0, 1'b0, 6, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h4000_0008, 4'hF, 32'h0, 0, 0, 0, 0, 0, AXI_RESP_SLVERR,
                    32'hDEAD_BEEF, 1'b0, 3, 1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 32'h8000_0030, 4'hF, 32'h0BAD_F00D, 0, 0, 0, 0, 0, AXI_RESP_DECERR,
                    32'h0, 1'b0, 3, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 32'h4000_000C, 4'hF, 32'h0, 0, 0, 0, 0, 0, AXI_RESP_OKAY,
                    32'hA5A5_5A5A, 1'b1, 3, 1'b0, 32'hA5A5_5A5A};
        vecs[6] = '{1'b1, 32'h8000_0040, 4'hC, 32'h1357_9BDF, 0, 2, 1, 0, 0, AXI_RESP_OKAY,
                    32'h0, 1'b0, 6, 1'b0, 32'h0};

        axi_idle();
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) do_txn(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.addr  = $urandom & 32'hFFFF_FFFC;
            v.be    = 4'($urandom);
            v.wdata = $urandom;
            v.aw_d  = $urandom_range(0, 5);
            v.w_d   = $urandom_range(0, 5);
            v.b_d   = $urandom_range(0, 5);
            v.ar_d  = $urandom_range(0, 5);
            v.r_d   = $urandom_range(0, 5);
            v.resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.rd    = $urandom;
            v.keep  = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_txn(model(v));
        end

        // Reset in the middle of a read: nothing may come back afterwards.
        @(negedge clk);
        axi_idle();
        host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 32'h1111_0000;
        #1 chk("mid_gnt", host_gnt_o, 1);
        @(negedge clk);
        host_req_i = 1'b0;
        chk("mid_arvalid", axi.arvalid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset("mid_rst");
        axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = 32'h7777_7777;
        rv_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (host_r_valid_o) rv_bad++;
        end
        chk("no_resp_after_reset", rv_bad, 0);
        axi_idle();
        last_rdata = '0;

`ifdef DM_SBA_TIMEOUT_EN
        begin
            int  c, lat;
            bit  held;
            @(negedge clk);
            host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 32'h9000_0000;
            #1 chk("tmo_gnt", host_gnt_o, 1);
            c = 0; lat = -1; held = 1;
            while (lat < 0 && c < 60) begin
                @(negedge clk);
                c++;
                if (host_r_valid_o) begin
                    lat = c;
                    chk("tmo_err", host_r_err_o, 1);
                    chk("tmo_rdata", host_r_rdata_o, 0);
                end else if (!axi.arvalid) held = 0;
            end
            chk("tmo_latency", lat, TMO + 1);
            chk("tmo_arvalid_held", held, 1);
            repeat (3) begin
                @(negedge clk);
                chk("drain_gnt", host_gnt_o, 0);
                chk("drain_arvalid", axi.arvalid, 1);
            end
            axi.arready = 1'b1;
            @(negedge clk);
            axi.arready = 1'b0;
            chk("drain_ar_dropped", axi.arvalid, 0);
            chk("drain_rready", axi.rready, 1);
            chk("drain_gnt2", host_gnt_o, 0);
            axi.rvalid = 1'b1; axi.rdata = 32'hBAD0_BAD0;
            @(negedge clk);
            axi.rvalid = 1'b0;
            chk("drain_done_gnt", host_gnt_o, 1);
            chk("drain_no_rvalid", host_r_valid_o, 0);
            chk("drain_discard", host_r_rdata_o, 0);
            host_req_i = 1'b0;

            @(negedge clk);
            host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 32'h9000_0100;
            #1 chk("tmo2_gnt", host_gnt_o, 1);
            @(negedge clk);
            host_req_i = 1'b0;
            c = 0; lat = -1;
            while (lat < 0 && c < 60) begin
                @(negedge clk);
                c++;
                if (host_r_valid_o) lat = c;
            end
            chk("tmo2_latency", lat, TMO);
            @(negedge clk);
            chk("tmo2_in_drain", axi.arvalid, 1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check_reset("drain_rst");
            host_req_i = 1'b1;
            #1 chk("drain_rst_idle", host_gnt_o, 1);
            host_req_i = 1'b0;
        end
`endif

        @(negedge clk);
        chk("final_rvalid", host_r_valid_o, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
